// File: rtl/addsub_result_stage.sv
// Capture stage for the ripple-carry adder/subtractor: derives {N,Z,C,V} and buffers results in a FIFO.
// Optional macro ADDSUB_SAT_EN enables saturation of the stored sum on signed overflow.
module addsub_result_stage #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned OVF_CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_sum,
    input  logic                       in_cout,
    input  logic                       in_ovf,
    input  logic                       in_mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_sum,
    output logic [3:0]                 out_flags,
    output logic [OVF_CNT_W-1:0]       ovf_count,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    logic [WIDTH-1:0]     sum_mem_q  [DEPTH];
    logic [3:0]           flag_mem_q [DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]      level_q, level_d;
    logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    logic                 push, pop;
    logic [WIDTH-1:0]     store_sum;
    logic [3:0]           store_flags;

    assign in_ready   = (level_q != LvlW'(DEPTH));
    assign out_valid  = (level_q != '0);
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign fifo_level = level_q;
    assign ovf_count  = ovf_cnt_q;

`ifdef ADDSUB_SAT_EN
    // A wrapped negative-looking sum on overflow means the true result was positive.
    always_comb begin
        store_sum = in_sum;
        if (in_ovf) begin
            store_sum = in_sum[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                        : {1'b1, {(WIDTH-1){1'b0}}};
        end
    end
`else
    assign store_sum = in_sum;
`endif

    // Subtract reports borrow, which is the inverse of the adder's C4.
    assign store_flags = {store_sum[WIDTH-1], (store_sum == '0), in_cout ^ in_mode, in_ovf};

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        ovf_cnt_d = ovf_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
        if (push && in_ovf && (ovf_cnt_q != '1)) begin
            ovf_cnt_d = ovf_cnt_q + OVF_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ovf_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    // Storage needs no reset: reads are gated by out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            sum_mem_q[wr_ptr_q]  <= store_sum;
            flag_mem_q[wr_ptr_q] <= store_flags;
        end
    end

    always_comb begin
        out_sum   = '0;
        out_flags = '0;
        if (out_valid) begin
            out_sum   = sum_mem_q[rd_ptr_q];
            out_flags = flag_mem_q[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_addsub_result_stage.sv
// Directed self-checking bench for addsub_result_stage (WIDTH=4, DEPTH=4, OVF_CNT_W=8).
module tb_addsub_result_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_sum;
    logic       in_cout;
    logic       in_ovf;
    logic       in_mode;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_sum;
    logic [3:0] out_flags;
    logic [7:0] ovf_count;
    logic [2:0] fifo_level;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    addsub_result_stage #(
        .WIDTH    (4),
        .DEPTH    (4),
        .OVF_CNT_W(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_cout   (in_cout),
        .in_ovf    (in_ovf),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_flags (out_flags),
        .ovf_count (ovf_count),
        .fifo_level(fifo_level)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] s, input logic c, input logic o,
                         input logic m);
        in_valid = v;
        in_sum   = s;
        in_cout  = c;
        in_ovf   = o;
        in_mode  = m;
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

        // 1. Reset
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ovf_count", 32'(ovf_count), 32'd0);
        check("rst_flags", 32'(out_flags), 32'd0);
        check("rst_sum", 32'(out_sum), 32'd0);
        rst = 1'b0;

        // 2. 5-5 = 0: N0 Z1 C0 V0
        drive(1'b1, 4'h0, 1'b1, 1'b0, 1'b1);
        step();
        drive(1'b0, 4'hf, 1'b1, 1'b1, 1'b1);
        check("t2_out_valid", 32'(out_valid), 32'd1);
        check("t2_sum", 32'(out_sum), 32'h0);
        check("t2_flags", 32'(out_flags), 32'b0100);
        check("t2_level", 32'(fifo_level), 32'd1);
        step();
        check("t2_ignored_invalid", 32'(fifo_level), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t2_popped_valid", 32'(out_valid), 32'd0);
        check("t2_empty_sum", 32'(out_sum), 32'd0);
        check("t2_empty_flags", 32'(out_flags), 32'd0);

        // 3. 7+1 overflows
        drive(1'b1, 4'b1000, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
`ifdef ADDSUB_SAT_EN
        check("t3_sum", 32'(out_sum), 32'b0111);
        check("t3_flags", 32'(out_flags), 32'b0001);
`else
        check("t3_sum", 32'(out_sum), 32'b1000);
        check("t3_flags", 32'(out_flags), 32'b1001);
`endif
        check("t3_ovf_count", 32'(ovf_count), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // 4. Fill: 1 add+carry, 2 add, 3 sub with borrow, 4 sub no borrow
        drive(1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b1, 4'd4, 1'b1, 1'b0, 1'b1);
        step();
        check("t4_full_level", 32'(fifo_level), 32'd4);
        check("t4_full_in_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
        step();
        check("t4_held_level", 32'(fifo_level), 32'd4);
        check("t4_held_sum", 32'(out_sum), 32'd1);
        check("t4_held_flags", 32'(out_flags), 32'b0010);
        out_ready = 1'b1;
        step();
        check("t4_pop1_level", 32'(fifo_level), 32'd3);
        check("t4_pop1_sum", 32'(out_sum), 32'd2);
        check("t4_pop1_flags", 32'(out_flags), 32'b0000);
        step();
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        check("t4_pop2_level", 32'(fifo_level), 32'd3);
        check("t4_pop2_sum", 32'(out_sum), 32'd3);
        check("t4_pop2_flags", 32'(out_flags), 32'b0010);
        step();
        check("t4_pop3_sum", 32'(out_sum), 32'd4);
        check("t4_pop3_flags", 32'(out_flags), 32'b0000);
        step();
        check("t4_fifth_sum", 32'(out_sum), 32'd5);
        check("t4_fifth_level", 32'(fifo_level), 32'd1);
        out_ready = 1'b0;

        // 5. Concurrent push/pop at level 2
        drive(1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
        step();
        check("t5_level2", 32'(fifo_level), 32'd2);
        out_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            drive(1'b1, 4'(7 + j), 1'b0, 1'b0, 1'b0);
            check($sformatf("t5_head_%0d", j), 32'(out_sum), 32'(5 + j));
            step();
            check($sformatf("t5_level_%0d", j), 32'(fifo_level), 32'd2);
        end
        out_ready = 1'b0;
        drive(1'b1, 4'd13, 1'b0, 1'b0, 1'b0);
        step();
        check("t5_level3", 32'(fifo_level), 32'd3);
        check("t5_head_after", 32'(out_sum), 32'd11);
        check("t5_ovf_before_rst", 32'(ovf_count), 32'd1);
        rst       = 1'b1;
        out_ready = 1'b1;
        step();
        rst       = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        check("t5_rst_level", 32'(fifo_level), 32'd0);
        check("t5_rst_out_valid", 32'(out_valid), 32'd0);
        check("t5_rst_ovf", 32'(ovf_count), 32'd0);
        check("t5_rst_in_ready", 32'(in_ready), 32'd1);

        // 6. Saturating overflow counter
        out_ready = 1'b1;
        drive(1'b1, 4'b1000, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 260; k++) begin
            step();
            if (k == 100) check("t6_count_100", 32'(ovf_count), 32'd100);
            if (k == 255) check("t6_count_255", 32'(ovf_count), 32'd255);
        end
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        check("t6_count_sat", 32'(ovf_count), 32'd255);
        check("t6_level", 32'(fifo_level), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
